// File: rtl/cam_chunk_buffer_ctrl_if.sv
// Camera-side, RAM-write and sender-handshake signals of cam_chunk_buffer_ctrl.
// The controller connects through the slave modport and the environment through master.
interface cam_chunk_buffer_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int BANK_W = 2
);
  logic                     pix_valid;
  logic [DATA_W-1:0]        cam_data;
  logic                     frame_done;
  logic                     ram_wr_en;
  logic [BANK_W+ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0]        ram_din;
  logic                     send_start;
  logic [BANK_W-1:0]        send_bank;
  logic [ADDR_W:0]          send_len;
  logic                     send_last;
  logic [15:0]              send_seq;
  logic                     eth_finish;
  logic                     overflow;
  logic [15:0]              drop_cnt;
  logic [1:0]               FSM_state;

  modport master (
    output pix_valid, cam_data, frame_done, eth_finish,
    input  ram_wr_en, ram_wr_addr, ram_din, send_start, send_bank, send_len,
           send_last, send_seq, overflow, drop_cnt, FSM_state
  );

  modport slave (
    input  pix_valid, cam_data, frame_done, eth_finish,
    output ram_wr_en, ram_wr_addr, ram_din, send_start, send_bank, send_len,
           send_last, send_seq, overflow, drop_cnt, FSM_state
  );
endinterface

// File: rtl/cam_chunk_buffer_ctrl.sv
// Packs camera bytes into rotating RAM banks and hands closed chunks
// (length, last-of-frame, sequence) to the Ethernet sender in fill order.
module cam_chunk_buffer_ctrl #(
  parameter int DATA_W     = 8,
  parameter int CHUNK_SIZE = 1400,
  parameter int ADDR_W     = 11,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cam_chunk_buffer_ctrl_if.slave bus
);

  // Status arrays span every encodable bank index; slots >= NUM_BANKS are never used.
  localparam int SLOTS = 1 << BANK_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_OFF  = ADDR_W'(CHUNK_SIZE - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W+1)'(CHUNK_SIZE);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  typedef struct packed {
    logic [ADDR_W:0] len;
    logic            last;
    logic [15:0]     seq;
  } chunk_t;

  logic [SLOTS-1:0]         full_q, full_d;
  chunk_t [SLOTS-1:0]       meta_q, meta_d;
  logic [BANK_W-1:0]        fill_bank_q, fill_bank_d;
  logic [BANK_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]        offset_q, offset_d;
  logic [15:0]              seq_q, seq_d;
  logic                     pending_q, pending_d;
  logic                     ram_wr_en_q, ram_wr_en_d;
  logic [BANK_W+ADDR_W-1:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [DATA_W-1:0]        ram_din_q, ram_din_d;
  logic                     overflow_q, overflow_d;
  logic [15:0]              drop_cnt_q, drop_cnt_d;
  logic [1:0]               state_q, state_d;
  logic                     send_start_q, send_start_d;
  logic [BANK_W-1:0]        send_bank_q, send_bank_d;
  logic [ADDR_W:0]          send_len_q, send_len_d;
  logic                     send_last_q, send_last_d;
  logic [15:0]              send_seq_q, send_seq_d;

  logic            writable, wr, drop, close, close_last;
  logic [ADDR_W:0] close_len;

  always_comb begin
    full_d        = full_q;
    meta_d        = meta_q;
    fill_bank_d   = fill_bank_q;
    rd_ptr_d      = rd_ptr_q;
    offset_d      = offset_q;
    seq_d         = seq_q;
    pending_d     = pending_q;
    ram_wr_en_d   = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_din_d     = ram_din_q;
    overflow_d    = overflow_q;
    drop_cnt_d    = drop_cnt_q;
    state_d       = state_q;
    send_start_d  = 1'b0;
    send_bank_d   = send_bank_q;
    send_len_d    = send_len_q;
    send_last_d   = send_last_q;
    send_seq_d    = send_seq_q;
    wr            = 1'b0;
    drop          = 1'b0;
    close         = 1'b0;
    close_last    = 1'b0;
    close_len     = '0;
    writable      = ~full_q[fill_bank_q];

    // A deferred end-of-frame marker claims the freed bank before any new pixel.
    if (writable && pending_q) begin
      close      = 1'b1;
      close_last = 1'b1;
      pending_d  = 1'b0;
      drop       = bus.pix_valid;
    end else if (writable) begin
      wr = bus.pix_valid;
      if (wr && offset_q == LAST_OFF) begin
        close      = 1'b1;
        close_len  = FULL_LEN;
        close_last = bus.frame_done;
      end else if (bus.frame_done) begin
        close      = 1'b1;
        close_last = 1'b1;
        close_len  = {1'b0, offset_q} + {{ADDR_W{1'b0}}, wr};
      end else if (wr) begin
        offset_d = offset_q + ADDR_W'(1);
      end
    end else begin
      drop = bus.pix_valid;
      if (bus.frame_done) pending_d = 1'b1;
    end

    if (wr) begin
      ram_wr_en_d   = 1'b1;
      ram_wr_addr_d = {fill_bank_q, offset_q};
      ram_din_d     = bus.cam_data;
    end

    if (close) begin
      full_d[fill_bank_q] = 1'b1;
      meta_d[fill_bank_q] = '{len: close_len, last: close_last, seq: seq_q};
      seq_d       = close_last ? 16'd0 : seq_q + 16'd1;
      offset_d    = '0;
      fill_bank_d = (fill_bank_q == LAST_BANK) ? '0 : fill_bank_q + BANK_W'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Sender side; the bank it frees is never the one being closed this cycle.
    case (state_q)
      S_IDLE: if (full_q[rd_ptr_q]) begin
        send_bank_d  = rd_ptr_q;
        send_len_d   = meta_q[rd_ptr_q].len;
        send_last_d  = meta_q[rd_ptr_q].last;
        send_seq_d   = meta_q[rd_ptr_q].seq;
        send_start_d = 1'b1;
        state_d      = S_START;
      end
      S_START: state_d = S_BUSY;
      S_BUSY: if (bus.eth_finish) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d = (rd_ptr_q == LAST_BANK) ? '0 : rd_ptr_q + BANK_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q        <= '0;
      meta_q        <= '0;
      fill_bank_q   <= '0;
      rd_ptr_q      <= '0;
      offset_q      <= '0;
      seq_q         <= '0;
      pending_q     <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_din_q     <= '0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
      state_q       <= S_IDLE;
      send_start_q  <= 1'b0;
      send_bank_q   <= '0;
      send_len_q    <= '0;
      send_last_q   <= 1'b0;
      send_seq_q    <= '0;
    end else begin
      full_q        <= full_d;
      meta_q        <= meta_d;
      fill_bank_q   <= fill_bank_d;
      rd_ptr_q      <= rd_ptr_d;
      offset_q      <= offset_d;
      seq_q         <= seq_d;
      pending_q     <= pending_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_din_q     <= ram_din_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= state_d;
      send_start_q  <= send_start_d;
      send_bank_q   <= send_bank_d;
      send_len_q    <= send_len_d;
      send_last_q   <= send_last_d;
      send_seq_q    <= send_seq_d;
    end
  end

  assign bus.ram_wr_en   = ram_wr_en_q;
  assign bus.ram_wr_addr = ram_wr_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.send_start  = send_start_q;
  assign bus.send_bank   = send_bank_q;
  assign bus.send_len    = send_len_q;
  assign bus.send_last   = send_last_q;
  assign bus.send_seq    = send_seq_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_cnt    = drop_cnt_q;
  assign bus.FSM_state   = state_q;

endmodule

// File: doc/cam_chunk_buffer_ctrl.md
Name: cam_chunk_buffer_ctrl

Overview:
- Parametrised successor of the camera-to-Ethernet write controller.
- Packs the camera pixel stream into NUM_BANKS rotating RAM banks of CHUNK_SIZE bytes each, and hands full or partial chunks to the Ethernet sender in fill order.
- Each chunk carries its length, a last-of-frame flag and a sequence number.
- Detects overflow when the sender falls behind, and flushes partial chunks on frame_done.

Parameters:
DATA_W, 8, camera/RAM data width
CHUNK_SIZE, 1400, bytes per full chunk (Ethernet payload)
ADDR_W, 11, offset width within a bank; 2^ADDR_W >= CHUNK_SIZE
NUM_BANKS, 2, bank count, 2..4
BANK_W, 2, bank index width, 2^BANK_W >= NUM_BANKS

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
pix_valid  in  1  cam_data valid this cycle
cam_data  in  DATA_W  pixel byte
frame_done  in  1  one-cycle pulse, end of camera frame
ram_wr_en  out  1  RAM write strobe
ram_wr_addr  out  BANK_W+ADDR_W  {fill_bank, offset}
ram_din  out  DATA_W  write data
send_start  out  1  one-cycle pulse, chunk ready for sender
send_bank  out  BANK_W  bank being sent; stable from send_start until eth_finish
send_len  out  ADDR_W+1  valid bytes in the chunk (0..CHUNK_SIZE)
send_last  out  1  chunk ends a frame
send_seq  out  16  chunk sequence number within the frame
eth_finish  in  1  one-cycle pulse, sender done with send_bank
overflow  out  1  sticky; cleared only by reset
drop_cnt  out  16  dropped pixel count, saturating
FSM_state  out  2  send FSM: 0 IDLE, 1 START, 2 BUSY

Behaviour:
- Reset values:
  - all outputs 0
  - all banks FREE; fill_bank=0, offset=0, read pointer=0
  - seq=0; pending_last=0
- Per-bank status: FREE / FILLING / FULL(len, last, seq).
- Write path, registered, 1-cycle latency: pix_valid with a writable bank gives ram_wr_en=1, ram_wr_addr={fill_bank, offset}, ram_din=cam_data on the next cycle; offset increments.
- Chunk close:
  - On a write at offset CHUNK_SIZE-1: bank becomes FULL with len=CHUNK_SIZE, last=0, seq=seq; seq increments.
  - fill_bank advances, wrapping NUM_BANKS-1 to 0; offset resets to 0.
- Target bank not FREE: no writable bank. Each pix_valid is then dropped (no RAM write), overflow=1 and drop_cnt increments, saturating at 0xFFFF. Writing resumes in the cycle after the target bank is freed.
- frame_done handling:
  - offset>0: close the bank with len=offset, last=1.
  - offset=0 and bank writable: close a zero-length end marker, len=0, last=1.
  - In both cases seq resets to 0 after the closed chunk is tagged.
  - No writable bank: set pending_last; when a bank becomes writable it is closed at once as a zero-length last marker, then pending_last clears.
- frame_done and pix_valid in the same cycle: the pixel is written first and is included in len. If it was byte CHUNK_SIZE-1, the close uses len=CHUNK_SIZE, last=1.
- Send FSM:
  - IDLE: if bank[rd_ptr] is FULL, load send_bank/len/last/seq and go to START.
  - START: send_start=1 for one cycle, then go to BUSY.
  - BUSY: on eth_finish, bank[rd_ptr] becomes FREE, rd_ptr advances with wrap, go to IDLE.
  - eth_finish in IDLE or START is ignored.
  - The minimum gap between consecutive send_start pulses is 3 cycles.
- A bank freed in the same cycle the fill side wants it is writable on the next cycle; a close and a free in the same cycle are both applied.
- Chunks are always sent in close order: no reordering, no bank skipping.
- Reset mid-operation: all state is discarded and the next cycle matches the reset values. The sender must also be reset.

Test Plan:
1. Reset, then 1400 consecutive pix_valid bytes 0x00..0x77 (wrapping mod 256) → addresses 0..1399 in bank 0; then send_start, send_bank=0, send_len=1400, send_last=0, send_seq=0, FSM_state=1 then 2.
2. 1500 pixels then frame_done, eth_finish returned promptly → chunk0 bank0 len 1400 last 0 seq 0; chunk1 bank1 len 100 last 1 seq 1; next frame restarts at seq 0.
3. NUM_BANKS=2, eth_finish withheld, 3000 pixels → banks 0 and 1 full, last 200 pixels dropped, overflow=1, drop_cnt=200; after eth_finish the next pixel is written to bank 0 offset 0.
4. frame_done together with pix_valid on byte 1399 → single chunk, len=1400, last=1, no zero-length marker.
5. frame_done with offset=0 → zero-length chunk, send_len=0, send_last=1; the sender's eth_finish frees it.
6. reset asserted while FSM_state=BUSY, mid-fill → next cycle all outputs 0, FSM_state=0, the next pixel is written at {0, 0}.
